// File: rtl/cpu_pkg.sv
// Shared encodings for the MiniRiscV multi-cycle controller: opcodes, FSM states,
// instruction classes and ALU operation codes.
package cpu_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        STORE  = 3'd1,
        BRANCH = 3'd2,
        RTYPE  = 3'd3,
        ITYPE  = 3'd4,
        OTHER  = 3'd5
    } iclass_t;

    localparam logic [1:0] ALU_LDST   = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_ARITH  = 2'b10;
    localparam logic [1:0] ALU_OTHER  = 2'b11;

    function automatic iclass_t classify(input logic [6:0] op);
        case (op)
            OP_LOAD:   return LOAD;
            OP_STORE:  return STORE;
            OP_BRANCH: return BRANCH;
            OP_RTYPE:  return RTYPE;
            OP_ITYPE:  return ITYPE;
            default:   return OTHER;
        endcase
    endfunction

    function automatic logic [1:0] alu_op_of(input iclass_t c);
        case (c)
            LOAD, STORE:  return ALU_LDST;
            BRANCH:       return ALU_BRANCH;
            RTYPE, ITYPE: return ALU_ARITH;
            default:      return ALU_OTHER;
        endcase
    endfunction

    function automatic logic uses_imm(input iclass_t c);
        return (c == LOAD) || (c == STORE) || (c == ITYPE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits unacknowledged; flags the cycle that would be
// the WAIT_TIMEOUT-th wait cycle. WAIT_TIMEOUT = 0 never expires.
module mem_wait_timer #(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en && (cnt != LAST))
            cnt <= cnt + CW'(1);
    end

    // cnt holds the wait cycles already completed, so this cycle is wait number cnt+1
    assign expired = (WAIT_TIMEOUT > 0) && en && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT) with memory wait timeout.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes into HALT with a sticky illegal flag.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             instr_done,
    output logic             bus_err,
    output logic [CNT_W-1:0] retire_cnt,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [2:0]       state
);

    state_t           state_q, state_d;
    iclass_t          cls_q;
    logic             bus_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wait_en, expired;

    assign wait_en = ((state_q == FETCH) && !imem_ready) ||
                     ((state_q == MEM)   && !dmem_ready);

    mem_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .en      (wait_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            cls_q     <= LOAD;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                cls_q <= classify(opcode);
            if (expired)
                bus_err_q <= 1'b1;
            if (instr_done)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_q <= 1'b0;
        else if ((state_q == EXEC) && (cls_q == OTHER))
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`endif

    // Every enable is held low while rst is high, so a mid-transaction reset drops requests at once
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = DECODE;
                    end else if (expired) begin
                        state_d = HALT;
                    end
                end
                DECODE: state_d = EXEC;
                EXEC: begin
                    alu_op  = alu_op_of(cls_q);
                    alu_src = uses_imm(cls_q);
                    case (cls_q)
                        BRANCH: begin
                            pc_we      = 1'b1;
                            pc_src     = zero;
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end
                        LOAD, STORE:  state_d = MEM;
                        RTYPE, ITYPE: state_d = WB;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            state_d = HALT;
`else
                            pc_we      = 1'b1;
                            instr_done = 1'b1;
                            state_d    = FETCH;
`endif
                        end
                    endcase
                end
                MEM: begin
                    alu_op   = alu_op_of(cls_q);
                    alu_src  = uses_imm(cls_q);
                    dmem_req = 1'b1;
                    dmem_we  = (cls_q == STORE);
                    if (dmem_ready) begin
                        if (cls_q == STORE) begin
                            pc_we      = 1'b1;
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end else if (expired) begin
                        state_d = HALT;
                    end
                end
                WB: begin
                    alu_op     = alu_op_of(cls_q);
                    alu_src    = uses_imm(cls_q);
                    reg_we     = 1'b1;
                    mem_to_reg = (cls_q == LOAD);
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                default: state_d = HALT;
            endcase
        end
    end

    assign bus_err    = bus_err_q;
    assign retire_cnt = cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds a per-cycle expected trace for each instruction from
// the phase/latency rules and replays it with randomized don't-care inputs.
module tb_multicycle_ctrl;

    localparam int TO = 16;
    localparam int CW = 4;

    localparam int C_LOAD = 0, C_STORE = 1, C_BRANCH = 2, C_RTYPE = 3, C_ITYPE = 4, C_OTHER = 5;
    localparam logic [6:0] OPC_LW = 7'b0000011, OPC_SW = 7'b0100011, OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_R  = 7'b0110011, OPC_I  = 7'b0010011;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          zero, imem_ready, dmem_ready;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, mem_to_reg, alu_src;
    logic [1:0]    alu_op;
    logic          instr_done, bus_err;
    logic [CW-1:0] retire_cnt;
    logic [2:0]    state;
    logic          illegal_w;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .instr_done(instr_done), .bus_err(bus_err),
        .retire_cnt(retire_cnt),
`ifdef ILLEGAL_TRAP_EN
        .illegal(illegal_w),
`endif
        .state(state)
    );

`ifndef ILLEGAL_TRAP_EN
    assign illegal_w = 1'b0;
`endif

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, mem_to_reg, alu_src;
        logic [1:0] alu_op;
        logic       instr_done;
    } outs_t;

    typedef struct {
        logic [2:0] st;
        outs_t      o;
        logic [6:0] op;
        logic       z, imr, dmr, be, il;
    } rec_t;

    outs_t got;
    assign got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, mem_to_reg,
                  alu_src, alu_op, instr_done};

    rec_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    logic model_be = 1'b0;
    logic model_il = 1'b0;

    function automatic rec_t mk(input logic [2:0] st);
        rec_t r;
        r.st  = st;
        r.o   = '0;
        r.op  = 7'($urandom);
        r.z   = 1'($urandom);
        r.imr = 1'($urandom);
        r.dmr = 1'($urandom);
        r.be  = model_be;
        r.il  = model_il;
        return r;
    endfunction

    function automatic outs_t with_alu(input outs_t o, input int c);
        o.alu_op  = (c == C_LOAD || c == C_STORE) ? 2'b00 :
                    (c == C_BRANCH) ? 2'b01 : (c == C_OTHER) ? 2'b11 : 2'b10;
        o.alu_src = (c == C_LOAD || c == C_STORE || c == C_ITYPE);
        return o;
    endfunction

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++) q.push_back(mk(3'd5));
    endtask

    // fd = wait cycles before imem_ready; md = wait cycles before dmem_ready, -1 = never
    task automatic build(input int c, input logic [6:0] opc, input int fd, input int md, input logic zv);
        rec_t r;
        int   n;
        for (int i = 0; i <= fd; i++) begin
            r = mk(3'd0);
            r.o.imem_req = 1'b1;
            r.imr        = (i == fd);
            r.o.ir_we    = (i == fd);
            q.push_back(r);
        end
        r = mk(3'd1);
        r.op = opc;
        q.push_back(r);
        r = mk(3'd2);
        r.o = with_alu(r.o, c);
        if (c == C_BRANCH) begin
            r.z = zv; r.o.pc_we = 1'b1; r.o.pc_src = zv; r.o.instr_done = 1'b1;
            q.push_back(r);
            return;
        end
        if (c == C_OTHER) begin
`ifdef ILLEGAL_TRAP_EN
            q.push_back(r);
            model_il = 1'b1;
            push_halt(4);
`else
            r.o.pc_we = 1'b1; r.o.instr_done = 1'b1;
            q.push_back(r);
`endif
            return;
        end
        q.push_back(r);
        if (c == C_LOAD || c == C_STORE) begin
            n = (md < 0) ? TO : md + 1;
            for (int i = 0; i < n; i++) begin
                r = mk(3'd3);
                r.o = with_alu(r.o, c);
                r.o.dmem_req = 1'b1;
                r.o.dmem_we  = (c == C_STORE);
                r.dmr        = (md >= 0 && i == md);
                if (r.dmr && c == C_STORE) begin
                    r.o.pc_we = 1'b1; r.o.instr_done = 1'b1;
                end
                q.push_back(r);
            end
            if (md < 0) begin
                model_be = 1'b1;
                push_halt(4);
                return;
            end
            if (c == C_STORE) return;
        end
        r = mk(3'd4);
        r.o = with_alu(r.o, c);
        r.o.reg_we = 1'b1; r.o.mem_to_reg = (c == C_LOAD); r.o.pc_we = 1'b1; r.o.instr_done = 1'b1;
        q.push_back(r);
    endtask

    // Entered and left at posedge+1; samples at posedge+2
    task automatic run_trace(input string tag, input int limit);
        rec_t r;
        int   n = 0;
        while (q.size() > 0 && n < limit) begin
            r = q.pop_front();
            opcode = r.op; zero = r.z; imem_ready = r.imr; dmem_ready = r.dmr;
            #1;
            vectors++;
            if (got !== r.o || state !== r.st || retire_cnt !== CW'(exp_cnt % (1 << CW)) ||
                bus_err !== r.be || illegal_w !== r.il) begin
                errors++;
                $display("FAIL %s cyc%0d: got outs=%h st=%0d cnt=%0d be=%b il=%b, expected outs=%h st=%0d cnt=%0d be=%b il=%b",
                         tag, n, got, state, retire_cnt, bus_err, illegal_w,
                         r.o, r.st, exp_cnt % (1 << CW), r.be, r.il);
            end
            if (r.o.instr_done) exp_cnt++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        model_be = 1'b0; model_il = 1'b0; exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1; opcode = OPC_SW;
        #1;
        vectors++;
        if ({got, state, retire_cnt, bus_err, illegal_w} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got outs=%h st=%0d cnt=%0d be=%b, expected all zero",
                     got, state, retire_cnt, bus_err);
        end
        do_reset();
    endtask

    task automatic test_add();
        do_reset();
        build(C_RTYPE, OPC_R, 0, 0, 1'b0);
        run_trace("add", 100);
        vectors++;
        if (retire_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL add_retire: got %0d, expected 1", retire_cnt);
        end
    endtask

    task automatic test_lw_delay();
        build(C_LOAD, OPC_LW, 0, 3, 1'b0);
        run_trace("lw_wait3", 100);
    endtask

    task automatic test_beq();
        build(C_BRANCH, OPC_BEQ, 0, 0, 1'b1);
        build(C_BRANCH, OPC_BEQ, 1, 0, 1'b0);
        build(C_ITYPE, OPC_I, 2, 0, 1'b0);
        run_trace("beq", 100);
    endtask

    task automatic test_sw_timeout();
        build(C_STORE, OPC_SW, 0, -1, 1'b0);
        run_trace("sw_timeout", 100);
    endtask

    task automatic test_ready_at_limit();
        do_reset();
        build(C_STORE, OPC_SW, TO - 1, TO - 1, 1'b0);
        build(C_LOAD, OPC_LW, 0, TO - 1, 1'b0);
        run_trace("ready_at_limit", 200);
    endtask

    task automatic test_other();
        do_reset();
        build(C_OTHER, 7'b1111111, 1, 0, 1'b0);
        build(C_RTYPE, OPC_R, 0, 0, 1'b0);
        run_trace("other_opcode", 100);
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        build(C_RTYPE, OPC_R, 0, 0, 1'b0);
        build(C_STORE, OPC_SW, 0, 6, 1'b0);
        run_trace("pre_mid_reset", 4 + 5);
        dmem_ready = 1'b0;
        #1;
        vectors++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || state !== 3'd3) begin
            errors++;
            $display("FAIL in_mem: got req=%b we=%b st=%0d, expected req=1 we=1 st=3", dmem_req, dmem_we, state);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({got, state, retire_cnt, bus_err} !== '0) begin
            errors++;
            $display("FAIL async_reset_drop: got outs=%h st=%0d cnt=%0d, expected all zero", got, state, retire_cnt);
        end
        q.delete(); exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || imem_req !== 1'b1 || retire_cnt !== CW'(0) || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL after_release: got st=%0d imem_req=%b cnt=%0d, expected st=0 imem_req=1 cnt=0",
                     state, imem_req, retire_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_stream();
        int         c;
        logic [6:0] opc;
        logic [6:0] others [4] = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b1101111};
        do_reset();
        for (int k = 0; k < 60; k++) begin
`ifdef ILLEGAL_TRAP_EN
            c = $urandom_range(0, 4);
`else
            c = $urandom_range(0, 5);
`endif
            case (c)
                C_LOAD:   opc = OPC_LW;
                C_STORE:  opc = OPC_SW;
                C_BRANCH: opc = OPC_BEQ;
                C_RTYPE:  opc = OPC_R;
                C_ITYPE:  opc = OPC_I;
                default:  opc = others[$urandom_range(0, 3)];
            endcase
            build(c, opc, $urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom));
            run_trace("random", 100);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_lw_delay();
        test_beq();
        test_sw_timeout();
        test_ready_at_limit();
        test_other();
        test_reset_mid_mem();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MiniRiscV datapath. Walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the PC, IR, register-file, ALU and memory-handshake enables.
- Supported set: beq, lw, sw, and, or, add, sub, addi, andi, ori.
- Sits between the instruction register/ALU-zero flag and the datapath muxes. It replaces single-cycle opcode decode with a Moore FSM plus memory wait/timeout handling.

Parameters:
- WAIT_TIMEOUT, 16, maximum cycles a memory request may stay unacknowledged before a bus error; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  7  inst[6:0] from the IR.
- zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction memory acknowledge.
- dmem_ready  in  1  data memory acknowledge.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write qualifier (sw).
- ir_we  out  1  IR load enable.
- pc_we  out  1  PC load enable.
- pc_src  out  1  0 selects pc+4, 1 selects branch target.
- reg_we  out  1  register-file write enable.
- mem_to_reg  out  1  writeback selects memory data.
- alu_src  out  1  ALU operand B selects immediate.
- alu_op  out  2  00 = ld/st, 01 = branch, 10 = R/I arithmetic, 11 = other.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- bus_err  out  1  sticky memory-timeout flag.
- retire_cnt  out  CNT_W  count of retired instructions.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset: async. State goes to FETCH; retire_cnt, bus_err and the class register clear. Every output is 0 during reset, except state = FETCH encoding (0).
- FETCH: imem_req = 1, held until imem_ready.
  - On the cycle imem_ready = 1: ir_we = 1, next state DECODE.
  - Wait counter increments every cycle spent waiting.
- DECODE: one cycle. Opcode is classified into the class register (LOAD, STORE, BRANCH, RTYPE, ITYPE, OTHER). Next state EXEC.
- EXEC: one cycle. alu_op and alu_src come from the class register, not live opcode: alu_src = 1 for LOAD/STORE/ITYPE.
  - BRANCH: pc_we = 1, pc_src = zero, instr_done = 1, next state FETCH.
  - LOAD/STORE: next state MEM.
  - RTYPE/ITYPE: next state WB.
  - OTHER: handled per Optional Feature.
- MEM: dmem_req = 1, and dmem_we = 1 if STORE. Both are held stable until dmem_ready.
  - On ready, STORE: pc_we = 1, instr_done = 1, next state FETCH.
  - On ready, LOAD: next state WB.
- WB: one cycle. reg_we = 1; mem_to_reg = 1 if LOAD; pc_we = 1; pc_src = 0; instr_done = 1. Next state FETCH.
- HALT: all enables 0. Left only by reset.
- Latency in cycles, with zero-wait memory: R/I = 4, beq = 3, sw = 4, lw = 5.
- Wait counter:
  - Clears on every state entry.
  - If WAIT_TIMEOUT > 0 and the count reaches WAIT_TIMEOUT while in FETCH or MEM without ready: bus_err is set and the next state is HALT. The request drops the following cycle.
- Ready asserted when not requesting is ignored.
- Ready arriving on the exact timeout cycle counts as success.
- retire_cnt increments on every instr_done and wraps modulo 2^CNT_W.
- pc_we never asserts in the same cycle as ir_we.
- All outputs are combinational from state and class only (Moore). The exceptions are pc_src (uses zero) and the ready-qualified ir_we, pc_we and instr_done.
- Reset mid-MEM: dmem_req/dmem_we drop immediately (async). No register write and no retire count occur.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an OTHER opcode in EXEC sets a sticky output illegal (port present only under the macro, reset 0). Next state HALT, with no PC update and no retire.
- Undefined: OTHER executes as a NOP. EXEC asserts pc_we = 1, pc_src = 0, instr_done = 1 and goes to FETCH. The illegal port is absent.

Decomposition:
- cpu_pkg holds:
  - opcode constants: LOAD 0000011, STORE 0100011, BRANCH 1100011, RTYPE 0110011, ITYPE 0010011;
  - the state enum: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5;
  - the instruction-class enum;
  - the alu_op encodings.
- One sub-module: mem_wait_timer (counter with clear, enable and timeout compare, parameterised by WAIT_TIMEOUT).

Test Plan:
1. add x3,x1,x2 (0x002081B3), zero-wait memory:
   - states FETCH, DECODE, EXEC, WB;
   - reg_we = 1, alu_op = 10, alu_src = 0 in WB;
   - instr_done and pc_we only in WB;
   - retire_cnt 0 to 1.
2. lw x3,0(x1) (0x0000A183), dmem_ready delayed 3 cycles:
   - dmem_req held 4 cycles with dmem_we = 0;
   - WB has mem_to_reg = 1;
   - total 8 cycles.
3. beq with zero = 1, then zero = 0:
   - EXEC asserts pc_we with pc_src = 1, then pc_src = 0;
   - no WB state; reg_we never asserted.
4. sw (opcode 0100011) with dmem_ready never asserted, WAIT_TIMEOUT = 16:
   - after 16 MEM cycles bus_err = 1, state = HALT, dmem_req = 0;
   - retire_cnt unchanged.
5. Opcode 1111111:
   - with ILLEGAL_TRAP_EN: illegal = 1, HALT;
   - without it: NOP retire, PC advances, retire_cnt increments.
6. rst pulsed mid-MEM of a sw:
   - outputs go 0 immediately with no clk edge;
   - state = FETCH and retire_cnt = 0 after release;
   - imem_req = 1 on the first cycle.
